filter_test_sequencer: RTL and testbench
========================================

FILTER_TEST_SEQUENCER -- requirements
Module: filter_test_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter ADDR_W, default 8, the ROM/RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, the sample width.
REQ-003 SHALL have parameter FILT_LAT, default 4, the filter latency in memClk cycles from filtIn to filtOut; legal range 1..15.

Ports:
REQ-004 memClk  input  1  sequencer clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle run request; sampled in IDLE only.
REQ-007 numSamples  input  ADDR_W  samples per run; 0 encodes 2^ADDR_W; latched on accepted start.
REQ-008 romAddr  output  ADDR_W  stimulus ROM address.
REQ-009 romData  input  DATA_W  ROM q; valid one cycle after romAddr.
REQ-010 filtIn  output  DATA_W  filter input sample.
REQ-011 filtOut  input  DATA_W  filter output, truncated.
REQ-012 ramAddr  output  ADDR_W  result RAM address.
REQ-013 ramData  output  DATA_W  result RAM write data.
REQ-014 ramWren  output  1  result RAM write enable.
REQ-015 ramQ  input  DATA_W  RAM q; valid one cycle after ramAddr.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse on entry to IDLE from DUMP.
REQ-018 dumpValid  output  1  dumpData holds a valid result.
REQ-019 dumpReady  input  1  consumer accepts dumpData.
REQ-020 dumpData  output  DATA_W  result stream, equal to ramQ.

Function
REQ-021 SHALL implement FSM states IDLE, FEED, DRAIN, DUMP with these transitions:
- IDLE->FEED on start.
- FEED->DRAIN after N ROM reads.
- DRAIN->DUMP after the last RAM write.
- DUMP->IDLE after the Nth dump handshake.
REQ-022 FEED: SHALL drive romAddr = k for k = 0..N-1, one per cycle, and filtIn = romData combinationally; filtIn SHALL be 0 in every cycle where no ROM read was issued in the previous cycle.
REQ-023 SHALL write the filter result of sample k at cycle (issue_k + 1 + FILT_LAT) with ramAddr = k, ramData = filtOut and ramWren = 1; writes are contiguous, N in total.
REQ-024 SHALL track write timing with a FILT_LAT+1 deep valid/address delay line; no free-running counter.
REQ-025 ramWren SHALL be 0 outside the N write cycles; during FEED/DRAIN, ramAddr SHALL be the pending write address.
REQ-026 DUMP read addressing:
- On DUMP entry, ramAddr = 0.
- dumpValid SHALL rise the following cycle.
- ramAddr = rdCnt+1 in a handshake cycle (dumpValid & dumpReady), otherwise rdCnt.
- Result: one result per cycle while dumpReady is held high.
REQ-027 While dumpValid=1 and dumpReady=0, dumpData and ramAddr SHALL hold stable.
REQ-028 dumpValid SHALL drop in the cycle after the Nth handshake, the same cycle done pulses.
REQ-029 start while busy SHALL be ignored; numSamples changes after acceptance SHALL have no effect.
REQ-030 Counters SHALL be ADDR_W+1 bits so that N = 2^ADDR_W completes without wrap ambiguity; addresses use the low ADDR_W bits.
REQ-031 Simultaneous done and start: start SHALL be ignored (sampled only in IDLE, i.e. from the next cycle).

Reset
REQ-032 rst=0 SHALL immediately force IDLE and set every output to 0 (romAddr, filtIn, ramAddr, ramData, ramWren, busy, done, dumpValid), clear counters and the delay line, and set the latched N to 0.
REQ-033 rst asserted mid-run SHALL abort with no further RAM write; the first run after release SHALL behave identically to a run from power-up.

Structure
REQ-034 State encodings and the default ADDR_W/DATA_W/FILT_LAT SHALL live in the shared filter-test defines file used by the test harness.
REQ-035 The latency delay line SHALL be one sub-module, lat_pipe (valid + ADDR_W address, depth parameter); all other logic SHALL be in filter_test_sequencer.

Verification
REQ-036 numSamples=4, FILT_LAT=4, ROM=identity-model filter, dumpReady=1 -> ramWren high cycles 6..9 after start with ramAddr 0..3; dump yields 4 consecutive beats; done pulses once.
REQ-037 numSamples=0 (N=256) -> 256 writes, addresses 0..255 with no duplicate, 256 dump beats, then IDLE.
REQ-038 numSamples=1 -> exactly one write at addr 0 and one dump beat; busy high for exactly 1+1+FILT_LAT+2 cycles plus dump stall cycles.
REQ-039 Dump with dumpReady toggling 1,0,0,1 -> dumpData stable across stall, no beat lost or repeated.
REQ-040 rst pulsed low in FEED at k=2 -> all outputs 0 immediately, no ramWren afterwards; the next start runs cleanly.
REQ-041 start re-pulsed during FEED and in the done cycle -> ignored; exactly one run executes.

Source files
------------

// File: rtl/filter_test_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : filter_test_sequencer_pkg
// Brief  : Shared filter-test defines: FSM state encoding and default widths.
// Rev    : 1.0  initial release
// ============================================================================
package filter_test_sequencer_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_FILT_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DUMP  = 2'd3
    } seqState_t;

endpackage
`default_nettype wire

// File: rtl/lat_pipe.sv
`default_nettype none
// ============================================================================
// Module : lat_pipe
// Brief  : Valid + address delay line matching the filter latency.
// Rev    : 1.0  initial release
// ============================================================================
module lat_pipe #(
    parameter int DEPTH  = 5,
    parameter int ADDR_W = 8
) (
    input  logic              memClk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [ADDR_W-1:0] inAddr,
    output logic              outValid,
    output logic [ADDR_W-1:0] outAddr
);

    logic [DEPTH-1:0]  r_valid;
    logic [ADDR_W-1:0] r_addr [DEPTH];

    // Address is zeroed when invalid so an idle slot never carries stale data.
    always_ff @(posedge memClk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_valid[0] <= inValid;
            r_addr[0]  <= inValid ? inAddr : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_addr[i]  <= r_addr[i-1];
            end
        end
    end

    assign outValid = r_valid[DEPTH-1];
    assign outAddr  = r_addr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/filter_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module : filter_test_sequencer
// Brief  : Streams ROM stimulus through a filter, stores results, dumps them.
// Rev    : 1.0  initial release
// ============================================================================
module filter_test_sequencer
    import filter_test_sequencer_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FILT_LAT = DEF_FILT_LAT
) (
    input  logic              memClk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] numSamples,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [DATA_W-1:0] romData,
    output logic [DATA_W-1:0] filtIn,
    input  logic [DATA_W-1:0] filtOut,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramData,
    output logic              ramWren,
    input  logic [DATA_W-1:0] ramQ,
    output logic              busy,
    output logic              done,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic [DATA_W-1:0] dumpData
);

    localparam int               c_cntW      = ADDR_W + 1;
    localparam int               c_pipeDepth = FILT_LAT + 1;
    localparam logic [c_cntW-1:0] c_one      = c_cntW'(1);

    seqState_t         r_state, w_stateNext;
    logic [c_cntW-1:0] r_numN, r_issueCnt, r_wrCnt, r_rdCnt;
    logic [c_cntW-1:0] w_issueNext, w_wrNext, w_rdNext, w_numDecoded;
    logic              r_romPending, r_done, r_dumpValid;
    logic              w_accept, w_issue, w_toDump, w_handshake, w_lastBeat;
    logic              w_pipeValid;
    logic [ADDR_W-1:0] w_pipeAddr;

    assign w_issueNext  = r_issueCnt + c_one;
    assign w_wrNext     = r_wrCnt + c_one;
    assign w_rdNext     = r_rdCnt + c_one;
    // A zero request means the full 2^ADDR_W address space.
    assign w_numDecoded = (numSamples == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, numSamples};

    lat_pipe #(
        .DEPTH  (c_pipeDepth),
        .ADDR_W (ADDR_W)
    ) u_latPipe (
        .memClk   (memClk),
        .rst      (rst),
        .inValid  (w_issue),
        .inAddr   (r_issueCnt[ADDR_W-1:0]),
        .outValid (w_pipeValid),
        .outAddr  (w_pipeAddr)
    );

    always_ff @(posedge memClk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_toDump    = 1'b0;
        w_handshake = 1'b0;
        w_lastBeat  = 1'b0;
        romAddr     = '0;
        ramAddr     = '0;
        case (r_state)
            ST_IDLE: begin
                // The done cycle still reads as IDLE but must not accept a new run.
                if (start && !r_done) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_FEED;
                end
            end
            ST_FEED: begin
                w_issue = 1'b1;
                romAddr = r_issueCnt[ADDR_W-1:0];
                ramAddr = w_pipeAddr;
                if (w_issueNext == r_numN) begin
                    w_stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                ramAddr = w_pipeAddr;
                if (w_pipeValid && (w_wrNext == r_numN)) begin
                    w_toDump    = 1'b1;
                    w_stateNext = ST_DUMP;
                end
            end
            ST_DUMP: begin
                w_handshake = r_dumpValid & dumpReady;
                ramAddr     = w_handshake ? w_rdNext[ADDR_W-1:0] : r_rdCnt[ADDR_W-1:0];
                if (w_handshake && (w_rdNext == r_numN)) begin
                    w_lastBeat  = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge memClk or negedge rst) begin
        if (!rst) begin
            r_numN       <= '0;
            r_issueCnt   <= '0;
            r_wrCnt      <= '0;
            r_rdCnt      <= '0;
            r_romPending <= 1'b0;
            r_done       <= 1'b0;
            r_dumpValid  <= 1'b0;
        end else begin
            r_romPending <= w_issue;
            r_done       <= w_lastBeat;
            r_dumpValid  <= (r_state == ST_DUMP) && !w_lastBeat;
            if (w_accept) begin
                r_numN     <= w_numDecoded;
                r_issueCnt <= '0;
                r_wrCnt    <= '0;
            end else begin
                if (w_issue) begin
                    r_issueCnt <= w_issueNext;
                end
                if (w_pipeValid) begin
                    r_wrCnt <= w_wrNext;
                end
            end
            if (w_toDump) begin
                r_rdCnt <= '0;
            end else if (w_handshake) begin
                r_rdCnt <= w_rdNext;
            end
        end
    end

    assign filtIn    = r_romPending ? romData : '0;
    assign ramWren   = w_pipeValid;
    assign ramData   = w_pipeValid ? filtOut : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign dumpValid = r_dumpValid;
    assign dumpData  = r_dumpValid ? ramQ : '0;

endmodule
`default_nettype wire

// File: tb/tb_filter_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_filter_test_sequencer
// Brief  : Directed bench with ROM/filter/RAM models and a timeline checker.
// Rev    : 1.0  initial release
// ============================================================================
module tb_filter_test_sequencer;

    localparam int L = 4;

    logic        memClk;
    logic        rst;
    logic        start;
    logic [7:0]  numSamples;
    logic [7:0]  romAddr;
    logic [31:0] romData;
    logic [31:0] filtIn;
    logic [31:0] filtOut;
    logic [7:0]  ramAddr;
    logic [31:0] ramData;
    logic        ramWren;
    logic [31:0] ramQ;
    logic        busy;
    logic        done;
    logic        dumpValid;
    logic        dumpReady;
    logic [31:0] dumpData;

    filter_test_sequencer #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .FILT_LAT (L)
    ) dut (
        .memClk     (memClk),
        .rst        (rst),
        .start      (start),
        .numSamples (numSamples),
        .romAddr    (romAddr),
        .romData    (romData),
        .filtIn     (filtIn),
        .filtOut    (filtOut),
        .ramAddr    (ramAddr),
        .ramData    (ramData),
        .ramWren    (ramWren),
        .ramQ       (ramQ),
        .busy       (busy),
        .done       (done),
        .dumpValid  (dumpValid),
        .dumpReady  (dumpReady),
        .dumpData   (dumpData)
    );

    initial begin
        memClk = 1'b0;
        forever #5 memClk = ~memClk;
    end

    function automatic logic [31:0] romVal(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b ^ 8'hA5, b + 8'd3, ~b, b};
    endfunction

    // Peripheral models: registered ROM, pure-delay filter, registered RAM.
    logic [31:0] fPipe [L];
    logic [31:0] mem [256];

    always @(posedge memClk) begin
        romData <= romVal(int'(romAddr));
        fPipe[0] <= filtIn;
        for (int i = 1; i < L; i++) fPipe[i] <= fPipe[i-1];
        if (ramWren === 1'b1) mem[ramAddr] <= ramData;
        ramQ <= mem[ramAddr];
    end
    assign filtOut = fPipe[L-1];

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ready pattern driver
    int       cyc = 0;
    int       readyMode = 0;
    logic [3:0] readyPat = 4'b1001;

    initial begin
        dumpReady = 1'b1;
        forever begin
            @(posedge memClk);
            #2;
            cyc++;
            dumpReady = (readyMode == 0) ? 1'b1 : readyPat[cyc % 4];
        end
    end

    // Observation counters (for literal pins) and the timeline model
    int firstWrenT, wrenCnt, beatCnt, doneCnt, busyCnt;
    int mT = 0, mN = 0, mBeat = 0, tD, k;
    bit mActive = 0, mDoneNext = 0;

    task automatic clearObs();
        firstWrenT = -1;
        wrenCnt = 0;
        beatCnt = 0;
        doneCnt = 0;
        busyCnt = 0;
    endtask

    initial begin : compare
        forever begin
            @(negedge memClk);
            if (!rst) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_dumpValid", 32'(dumpValid), 32'd0);
                check("rst_ramWren", 32'(ramWren), 32'd0);
                check("rst_romAddr", 32'(romAddr), 32'd0);
                check("rst_ramAddr", 32'(ramAddr), 32'd0);
                check("rst_filtIn", filtIn, 32'd0);
                check("rst_ramData", ramData, 32'd0);
                mActive = 0;
                mDoneNext = 0;
                mBeat = 0;
                mT = 0;
            end else begin
                if (ramWren === 1'b1) begin
                    wrenCnt++;
                    if (firstWrenT < 0) firstWrenT = mT;
                end
                if (busy === 1'b1) busyCnt++;
                if (done === 1'b1) doneCnt++;
                if (dumpValid === 1'b1 && dumpReady) beatCnt++;
                check("done", 32'(done), 32'(mDoneNext));
                if (!mActive) begin
                    check("idle_busy", 32'(busy), 32'd0);
                    check("idle_ramWren", 32'(ramWren), 32'd0);
                    check("idle_dumpValid", 32'(dumpValid), 32'd0);
                    if (start && !mDoneNext) begin
                        mActive = 1;
                        mT = 1;
                        mBeat = 0;
                        mN = (numSamples == 8'd0) ? 256 : int'(numSamples);
                    end
                    mDoneNext = 0;
                end else begin
                    check("busy", 32'(busy), 32'd1);
                    if (mT <= mN) check("romAddr", 32'(romAddr), 32'((mT - 1) & 255));
                    if (mT >= 2 && mT <= mN + 1) check("filtIn", filtIn, romVal(mT - 2));
                    else check("filtIn_idle", filtIn, 32'd0);
                    k = mT - 2 - L;
                    if (k >= 0 && k < mN) begin
                        check("ramWren", 32'(ramWren), 32'd1);
                        check("wrAddr", 32'(ramAddr), 32'(k & 255));
                        check("ramData", ramData, romVal(k));
                    end else begin
                        check("ramWren_off", 32'(ramWren), 32'd0);
                    end
                    tD = mN + L + 2;
                    if (mT == tD) begin
                        check("dumpEntryAddr", 32'(ramAddr), 32'd0);
                        check("dumpValid_entry", 32'(dumpValid), 32'd0);
                    end else if (mT > tD) begin
                        check("dumpValid", 32'(dumpValid), 32'd1);
                        check("dumpData", dumpData, romVal(mBeat));
                        check("rdAddr", 32'(ramAddr), 32'((dumpReady ? mBeat + 1 : mBeat) & 255));
                        if (dumpReady) begin
                            mBeat++;
                            if (mBeat == mN) begin
                                mActive = 0;
                                mDoneNext = 1;
                            end
                        end
                    end else begin
                        check("dumpValid_off", 32'(dumpValid), 32'd0);
                    end
                    mT++;
                end
            end
        end
    end

    task automatic startRun(input logic [7:0] n);
        @(posedge memClk);
        #2;
        start = 1'b1;
        numSamples = n;
        @(posedge memClk);
        #2;
        start = 1'b0;
        numSamples = 8'($urandom_range(1, 255));
    endtask

    task automatic waitDone(input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge memClk);
            #2;
            if (done === 1'b1) seen = 1;
        end
        check("doneTimeout", 32'(seen), 32'd1);
        repeat (3) @(posedge memClk);
        #2;
    endtask

    initial begin : driver
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < L; i++) fPipe[i] = 32'd0;
        rst = 1'b1;
        start = 1'b0;
        numSamples = 8'd0;
        clearObs();
        #3 rst = 1'b0;
        repeat (3) @(posedge memClk);
        #2 rst = 1'b1;
        repeat (2) @(posedge memClk);
        #2;
        check("postReset_busy", 32'(busy), 32'd0);

        // Basic run, N=4
        clearObs();
        startRun(8'd4);
        waitDone(200);
        check("n4_firstWrenT", 32'(firstWrenT), 32'd6);
        check("n4_wrenCnt", 32'(wrenCnt), 32'd4);
        check("n4_beatCnt", 32'(beatCnt), 32'd4);
        check("n4_doneCnt", 32'(doneCnt), 32'd1);

        // Single sample
        clearObs();
        startRun(8'd1);
        waitDone(200);
        check("n1_busyCnt", 32'(busyCnt), 32'(1 + 1 + L + 2));
        check("n1_wrenCnt", 32'(wrenCnt), 32'd1);
        check("n1_beatCnt", 32'(beatCnt), 32'd1);

        // Dump with ready toggling 1,0,0,1
        clearObs();
        readyMode = 1;
        startRun(8'd3);
        waitDone(200);
        readyMode = 0;
        check("tog_beatCnt", 32'(beatCnt), 32'd3);
        check("tog_wrenCnt", 32'(wrenCnt), 32'd3);

        // Start re-pulsed in FEED and in the done cycle
        clearObs();
        startRun(8'd6);
        @(posedge memClk);
        #2;
        start = 1'b1;
        numSamples = 8'd9;
        @(posedge memClk);
        #2;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge memClk);
            #2;
            if (done === 1'b1) seen = 1;
        end
        check("ign_doneSeen", 32'(seen), 32'd1);
        start = 1'b1;
        numSamples = 8'd7;
        @(posedge memClk);
        #2;
        start = 1'b0;
        repeat (5) @(posedge memClk);
        #2;
        check("ign_busyAfter", 32'(busy), 32'd0);
        check("ign_doneCnt", 32'(doneCnt), 32'd1);
        check("ign_wrenCnt", 32'(wrenCnt), 32'd6);

        // Reset mid-FEED at k=2, then a clean run
        startRun(8'd5);
        @(posedge memClk);
        #2;
        @(posedge memClk);
        #2;
        check("abort_romAddr", 32'(romAddr), 32'd2);
        clearObs();
        rst = 1'b0;
        #1;
        check("abort_immBusy", 32'(busy), 32'd0);
        check("abort_immRomAddr", 32'(romAddr), 32'd0);
        repeat (2) @(posedge memClk);
        #2 rst = 1'b1;
        repeat (12) @(posedge memClk);
        #2;
        check("abort_noWren", 32'(wrenCnt), 32'd0);
        clearObs();
        startRun(8'd4);
        waitDone(200);
        check("rerun_firstWrenT", 32'(firstWrenT), 32'd6);
        check("rerun_beatCnt", 32'(beatCnt), 32'd4);

        // Full address space, N=256
        clearObs();
        startRun(8'd0);
        waitDone(1000);
        check("n256_wrenCnt", 32'(wrenCnt), 32'd256);
        check("n256_beatCnt", 32'(beatCnt), 32'd256);
        check("n256_doneCnt", 32'(doneCnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
